flash_read_checker: RTL and testbench
=====================================

// Module: flash_read_checker
// PURPOSE
// - Consumes the read byte stream of the SPI NOR flash controller (rd data + RdDataValid strobe) in on-board test.
// - Compares each byte against a locally generated expected pattern; counts bytes and mismatches.
// - Captures the first failing index/data; reports pass/fail/timeout to the test top (LEDs and logic-analyzer probes).
// PARAMETERS
// - BYTE_CNT_W  24        width of byte count and byte index
// - ERR_CNT_W   16        width of mismatch counter; saturates at all-ones
// - TIMEOUT_W   22        width of inter-byte watchdog counter
// - TIMEOUT_MAX 22'h3FFFFF  idle cycles without a valid byte before timeout; must be >= 1
// PORTS
// - i_clock               in   1           system clock; all logic on rising edge
// - i_reset_n             in   1           asynchronous, active-low reset
// - i_start               in   1           1-cycle pulse: arm a new check run
// - i_byte_count          in   BYTE_CNT_W  bytes expected in the run; sampled on accepted start
// - i_seed                in   8           pattern seed; sampled on accepted start
// - i_pattern_mode        in   1           0 = incrementing, 1 = LFSR; sampled on accepted start
// - i_rd_data             in   8           byte from flash controller
// - i_rd_valid            in   1           1-cycle strobe: i_rd_data valid this cycle
// - o_busy                out  1           run in progress
// - o_done                out  1           run finished; level, held until next accepted start
// - o_pass                out  1           valid only with o_done: 1 = all bytes matched, no timeout
// - o_timeout             out  1           run ended by watchdog
// - o_bytes_seen          out  BYTE_CNT_W  bytes consumed in current/last run
// - o_err_count           out  ERR_CNT_W   mismatches, saturating
// - o_first_err_index     out  BYTE_CNT_W  index of first mismatch (0-based)
// - o_first_err_data      out  8           received byte at first mismatch
// - o_first_err_expected  out  8           expected byte at first mismatch
// BEHAVIOUR
// - Reset: state IDLE; every output 0; seed/config registers 0.
// - States: IDLE -> (start) CHECKING -> DONE_PASS | DONE_FAIL; DONE_* -> (start) CHECKING.
// - Start: accepted only in IDLE/DONE_*; ignored while CHECKING.
// - Start: accepted start clears counters, captures, o_done, o_timeout, o_pass; o_busy=1 next cycle.
// - Start: i_rd_valid coincident with an accepted start is discarded.
// - i_byte_count==0 on start: enter CHECKING for one cycle, then DONE_PASS.
// - i_rd_valid outside CHECKING: ignored entirely.
// - Expected byte, incrementing mode: exp[n] = (seed + n) mod 256.
// - Expected byte, LFSR mode: exp[0] = seed (8'h00 replaced by 8'h01).
// - Expected byte, LFSR mode: exp[n+1] = {exp[n][6:0], exp[n][7]^exp[n][5]^exp[n][4]^exp[n][3]}.
// - Generator advances only on a consumed valid byte.
// - Per valid byte: compare and increment o_bytes_seen in the same edge.
// - Mismatch: o_err_count+1, saturating at all-ones.
// - First mismatch only: load o_first_err_index/o_first_err_data/o_first_err_expected; later mismatches never overwrite them.
// - Last byte (bytes_seen reaches byte_count): next cycle o_busy=0, o_done=1.
// - Last byte: go to DONE_PASS if err_count==0, else DONE_FAIL; result includes the last byte's compare.
// - Watchdog: cleared on start and on every consumed byte; counts CHECKING cycles.
// - Watchdog: at TIMEOUT_MAX go to DONE_FAIL with o_timeout=1; counts/captures keep their values.
// - Simultaneous valid and watchdog expiry: the byte is consumed and the watchdog is cleared; no timeout.
// - o_pass = (state==DONE_PASS). Bytes beyond i_byte_count are dropped; the run is already done.
// - i_reset_n low mid-run: immediate return to reset values; no partial result is retained.
// STRUCTURE
// - Package flash_chk_pkg: state enum (IDLE, CHECKING, DONE_PASS, DONE_FAIL), PAT_INCR/PAT_LFSR constants,
//   lfsr8_next() function.
// - Sub-module flash_pattern_gen: load(seed, mode) and advance inputs; registered 8-bit exp output.
// - Checker FSM, counters and first-error capture live in the top.
// TESTING
// - Pass, incrementing: seed=8'h10, count=4, feed 10,11,12,13 -> o_done=1, o_pass=1, err=0, bytes_seen=4.
// - Pass, LFSR: seed=8'h00, count=3, feed 01,02,04 -> o_pass=1; seed is forced to 8'h01.
// - Mismatch: seed=0, incr, count=5, feed 00,01,FF,03,EE -> err=2, first_idx=2, first_data=FF, first_exp=02, pass=0.
// - Timeout: TIMEOUT_MAX=16, count=4, feed 2 bytes then stall -> after 16 cycles o_done=1, o_timeout=1, bytes_seen=2.
// - Boundary: count=0 -> DONE_PASS 2 cycles after start; start during CHECKING ignored; valid in IDLE ignored.
// - Boundary: valid on the expiry cycle -> no timeout.
// - Reset mid-run: assert i_reset_n=0 after 2 bytes -> all outputs 0; new start runs clean.
// - Saturation: ERR_CNT_W=2, feed 6 mismatching bytes -> err_count=3.

Source files
------------

// File: rtl/flash_chk_pkg.sv
// Shared types and helpers for the flash read-back checker.
package flash_chk_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECKING  = 2'd1,
    DONE_PASS = 2'd2,
    DONE_FAIL = 2'd3
  } state_t;

  localparam logic PAT_INCR = 1'b0;
  localparam logic PAT_LFSR = 1'b1;

  // Fibonacci LFSR, taps 8/6/5/4, shifting left
  function automatic logic [7:0] lfsr8_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage

// File: rtl/flash_pattern_gen.sv
// Expected-byte generator: incrementing or LFSR sequence, advanced once per consumed byte.
module flash_pattern_gen
  import flash_chk_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       mode,
  input  logic       advance,
  output logic [7:0] exp_byte
);

  logic mode_r;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      exp_byte <= 8'h00;
      mode_r   <= PAT_INCR;
    end else if (load) begin
      mode_r <= mode;
      // an all-zero LFSR would lock up, so seed 0 becomes 1
      if (mode == PAT_LFSR && seed == 8'h00) exp_byte <= 8'h01;
      else                                   exp_byte <= seed;
    end else if (advance) begin
      if (mode_r == PAT_LFSR) exp_byte <= lfsr8_next(exp_byte);
      else                    exp_byte <= exp_byte + 8'h01;
    end
  end

endmodule

// File: rtl/flash_read_checker.sv
// Checks the flash read byte stream against a generated pattern; counts bytes/errors,
// captures the first mismatch and guards the run with an inter-byte watchdog.
//   state     | meaning
//   IDLE      | out of reset, waiting for first start
//   CHECKING  | run armed, consuming bytes
//   DONE_PASS | all bytes matched
//   DONE_FAIL | mismatch seen or watchdog expired
module flash_read_checker
  import flash_chk_pkg::*;
#(
  parameter int BYTE_CNT_W = 24,
  parameter int ERR_CNT_W  = 16,
  parameter int TIMEOUT_W  = 22,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = 22'h3FFFFF
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic [BYTE_CNT_W-1:0] i_byte_count,
  input  logic [7:0]            i_seed,
  input  logic                  i_pattern_mode,
  input  logic [7:0]            i_rd_data,
  input  logic                  i_rd_valid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_timeout,
  output logic [BYTE_CNT_W-1:0] o_bytes_seen,
  output logic [ERR_CNT_W-1:0]  o_err_count,
  output logic [BYTE_CNT_W-1:0] o_first_err_index,
  output logic [7:0]            o_first_err_data,
  output logic [7:0]            o_first_err_expected
);

  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_MAX - 1'b1;

  state_t                state;
  logic [BYTE_CNT_W-1:0] byte_count_r;
  logic [TIMEOUT_W-1:0]  wdog;
  logic [7:0]            exp_byte;
  logic                  start_ok;
  logic                  consume;
  logic                  mismatch;
  logic                  last_byte;
  logic [ERR_CNT_W-1:0]  err_next;

  assign start_ok  = i_start && (state != CHECKING);
  assign consume   = i_rd_valid && (state == CHECKING) && (byte_count_r != '0);
  assign mismatch  = consume && (i_rd_data != exp_byte);
  assign last_byte = consume && ((o_bytes_seen + 1'b1) == byte_count_r);

  always_comb begin
    err_next = o_err_count;
    if (mismatch && (o_err_count != {ERR_CNT_W{1'b1}})) err_next = o_err_count + 1'b1;
  end

  flash_pattern_gen u_pattern_gen (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .load      (start_ok),
    .seed      (i_seed),
    .mode      (i_pattern_mode),
    .advance   (consume),
    .exp_byte  (exp_byte)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state                <= IDLE;
      byte_count_r         <= '0;
      wdog                 <= '0;
      o_busy               <= 1'b0;
      o_done               <= 1'b0;
      o_pass               <= 1'b0;
      o_timeout            <= 1'b0;
      o_bytes_seen         <= '0;
      o_err_count          <= '0;
      o_first_err_index    <= '0;
      o_first_err_data     <= 8'h00;
      o_first_err_expected <= 8'h00;
    end else begin
      case (state)
        IDLE, DONE_PASS, DONE_FAIL: begin
          if (i_start) begin
            state                <= CHECKING;
            byte_count_r         <= i_byte_count;
            wdog                 <= '0;
            o_busy               <= 1'b1;
            o_done               <= 1'b0;
            o_pass               <= 1'b0;
            o_timeout            <= 1'b0;
            o_bytes_seen         <= '0;
            o_err_count          <= '0;
            o_first_err_index    <= '0;
            o_first_err_data     <= 8'h00;
            o_first_err_expected <= 8'h00;
          end
        end
        CHECKING: begin
          if (byte_count_r == '0) begin
            state  <= DONE_PASS;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            o_pass <= 1'b1;
          end else if (consume) begin
            // a byte on the expiry cycle still counts and rearms the watchdog
            wdog         <= '0;
            o_bytes_seen <= o_bytes_seen + 1'b1;
            o_err_count  <= err_next;
            if (mismatch && (o_err_count == '0)) begin
              o_first_err_index    <= o_bytes_seen;
              o_first_err_data     <= i_rd_data;
              o_first_err_expected <= exp_byte;
            end
            if (last_byte) begin
              state  <= (err_next == '0) ? DONE_PASS : DONE_FAIL;
              o_busy <= 1'b0;
              o_done <= 1'b1;
              o_pass <= (err_next == '0);
            end
          end else if (wdog == WDOG_LAST) begin
            state     <= DONE_FAIL;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
            o_timeout <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_read_checker.sv
// Directed self-checking bench for flash_read_checker (ERR_CNT_W=2, TIMEOUT_MAX=16).
module tb_flash_read_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] byte_count;
  logic [7:0]  seed;
  logic        mode;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy, done, pass, timeout;
  logic [23:0] bytes_seen, first_idx;
  logic [1:0]  err_count;
  logic [7:0]  first_data, first_exp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flash_read_checker #(
    .BYTE_CNT_W (24),
    .ERR_CNT_W  (2),
    .TIMEOUT_W  (22),
    .TIMEOUT_MAX(22'd16)
  ) dut (
    .i_clock              (clk),
    .i_reset_n            (rst_n),
    .i_start              (start),
    .i_byte_count         (byte_count),
    .i_seed               (seed),
    .i_pattern_mode       (mode),
    .i_rd_data            (rd_data),
    .i_rd_valid           (rd_valid),
    .o_busy               (busy),
    .o_done               (done),
    .o_pass               (pass),
    .o_timeout            (timeout),
    .o_bytes_seen         (bytes_seen),
    .o_err_count          (err_count),
    .o_first_err_index    (first_idx),
    .o_first_err_data     (first_data),
    .o_first_err_expected (first_exp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [23:0] cnt, input logic [7:0] sd, input logic md);
    byte_count = cnt;
    seed       = sd;
    mode       = md;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    rd_data  = b;
    rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic chk_result(input string tag, input logic p, input logic t,
                            input logic [23:0] seen, input logic [1:0] errs);
    chk({tag, "_busy"},    {31'd0, busy},    32'd0);
    chk({tag, "_done"},    {31'd0, done},    32'd1);
    chk({tag, "_pass"},    {31'd0, pass},    {31'd0, p});
    chk({tag, "_timeout"}, {31'd0, timeout}, {31'd0, t});
    chk({tag, "_seen"},    {8'd0, bytes_seen}, {8'd0, seen});
    chk({tag, "_err"},     {30'd0, err_count}, {30'd0, errs});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flags"}, {28'd0, busy, done, pass, timeout}, 32'd0);
    chk({tag, "_seen"},  {8'd0, bytes_seen}, 32'd0);
    chk({tag, "_err"},   {30'd0, err_count}, 32'd0);
    chk({tag, "_fidx"},  {8'd0, first_idx},  32'd0);
    chk({tag, "_fdat"},  {24'd0, first_data}, 32'd0);
    chk({tag, "_fexp"},  {24'd0, first_exp},  32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; byte_count = '0; seed = '0; mode = 1'b0;
    rd_data = '0; rd_valid = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // valid in IDLE is ignored
    send(8'h00);
    chk("idle_valid_seen", {8'd0, bytes_seen}, 32'd0);
    chk("idle_valid_busy", {31'd0, busy}, 32'd0);

    // incrementing pass; a start mid-run must be ignored
    do_start(24'd4, 8'h10, 1'b0);
    chk("incr_busy", {31'd0, busy}, 32'd1);
    send(8'h10); send(8'h11);
    do_start(24'd9, 8'h55, 1'b1);
    send(8'h12); send(8'h13);
    chk_result("incr", 1'b1, 1'b0, 24'd4, 2'd0);
    // extra byte after done is dropped
    send(8'h14);
    chk("post_done_seen", {8'd0, bytes_seen}, 32'd4);

    // LFSR with zero seed forced to 01
    do_start(24'd3, 8'h00, 1'b1);
    send(8'h01); send(8'h02); send(8'h04);
    chk_result("lfsr0", 1'b1, 1'b0, 24'd3, 2'd0);

    // LFSR with feedback bit set: 81 -> 03 -> 06, mismatch at index 2
    do_start(24'd3, 8'h81, 1'b1);
    send(8'h81); send(8'h03); send(8'h07);
    chk_result("lfsr_fb", 1'b0, 1'b0, 24'd3, 2'd1);
    chk("lfsr_fb_fidx", {8'd0, first_idx}, 32'd2);
    chk("lfsr_fb_fdat", {24'd0, first_data}, 32'h07);
    chk("lfsr_fb_fexp", {24'd0, first_exp}, 32'h06);

    // mismatch run; valid coincident with start is discarded
    rd_valid = 1'b1; rd_data = 8'h00;
    do_start(24'd5, 8'h00, 1'b0);
    rd_valid = 1'b0;
    chk("start_valid_seen", {8'd0, bytes_seen}, 32'd0);
    send(8'h00); send(8'h01); send(8'hFF); send(8'h03); send(8'hEE);
    chk_result("mism", 1'b0, 1'b0, 24'd5, 2'd2);
    chk("mism_fidx", {8'd0, first_idx}, 32'd2);
    chk("mism_fdat", {24'd0, first_data}, 32'hFF);
    chk("mism_fexp", {24'd0, first_exp}, 32'h02);

    // zero-length run: DONE_PASS two cycles after start
    do_start(24'd0, 8'h33, 1'b0);
    chk("zero_busy", {31'd0, busy}, 32'd1);
    chk("zero_done_early", {31'd0, done}, 32'd0);
    tick();
    chk_result("zero", 1'b1, 1'b0, 24'd0, 2'd0);

    // watchdog timeout after 16 idle cycles
    do_start(24'd4, 8'h20, 1'b0);
    send(8'h20); send(8'h21);
    repeat (15) tick();
    chk("to_not_yet", {31'd0, done}, 32'd0);
    tick();
    chk_result("to", 1'b0, 1'b1, 24'd2, 2'd0);

    // byte on the expiry cycle rearms the watchdog
    do_start(24'd3, 8'h40, 1'b0);
    send(8'h40);
    repeat (15) tick();
    send(8'h41);
    chk("exp_valid_busy", {31'd0, busy}, 32'd1);
    chk("exp_valid_to", {31'd0, timeout}, 32'd0);
    chk("exp_valid_seen", {8'd0, bytes_seen}, 32'd2);
    send(8'h42);
    wait_done("exp_valid_done", 30);
    chk_result("exp_valid", 1'b1, 1'b0, 24'd3, 2'd0);

    // reset mid-run wipes everything; a fresh run is clean
    do_start(24'd4, 8'h00, 1'b0);
    send(8'h00); send(8'h77);
    rst_n = 1'b0;
    #2;
    chk_all_zero("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    do_start(24'd2, 8'hFE, 1'b0);
    send(8'hFE); send(8'hFF);
    chk_result("after_rst", 1'b1, 1'b0, 24'd2, 2'd0);

    // error counter saturates at 3
    do_start(24'd6, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) send(8'hAA);
    chk_result("sat", 1'b0, 1'b0, 24'd6, 2'd3);
    chk("sat_fidx", {8'd0, first_idx}, 32'd0);
    chk("sat_fdat", {24'd0, first_data}, 32'hAA);
    chk("sat_fexp", {24'd0, first_exp}, 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
